// File: rtl/booth_seq.sv
// Sequential radix-2 Booth controller for 8x8 signed multiply.
// Drives an external registered add/sub stage and shifts in its result.
module booth_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [7:0]  as_in1,
    output logic [7:0]  as_in2,
    output logic        as_op,
    input  logic [7:0]  as_result,
    input  logic        as_of,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] a;
    logic [7:0] q;
    logic       q_1;
    logic [7:0] m;
    logic [3:0] cnt;

    logic [7:0] src;
    logic       s;
    logic [7:0] a_nx;
    logic [7:0] q_nx;
    logic [3:0] cnt_nx;

    assign as_in1 = a;
    assign as_in2 = m;
    assign as_op  = q[0] & ~q_1;

    // Overflow-corrected sign keeps the 9-bit true sum, so M = -128 works.
    always_comb begin
        src = a;
        s   = a[7];
        if (q[0] ^ q_1) begin
            src = as_result;
            s   = as_result[7] ^ as_of;
        end
        a_nx   = {s, src[7:1]};
        q_nx   = {src[0], q[7:1]};
        cnt_nx = cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            a       <= 8'd0;
            q       <= 8'd0;
            q_1     <= 1'b0;
            m       <= 8'd0;
            cnt     <= 4'd0;
            product <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= 8'd0;
                        q     <= multiplier;
                        q_1   <= 1'b0;
                        m     <= multiplicand;
                        cnt   <= 4'd8;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    q_1 <= q[0];
                    cnt <= cnt_nx;
                    if (cnt_nx == 4'd0) begin
                        product <= {a_nx, q_nx};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq.sv
// Directed bench for booth_seq with a registered add/sub stage model.
// Expected products are hand-computed signed 8x8 results.
module tb_booth_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  as_in1;
    logic [7:0]  as_in2;
    logic        as_op;
    logic [7:0]  as_result;
    logic        as_of;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic of_seen;
    logic both_seen;

    booth_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .as_in1       (as_in1),
        .as_in2       (as_in2),
        .as_op        (as_op),
        .as_result    (as_result),
        .as_of        (as_of),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    // addSub: one-cycle registered add/subtract with signed overflow flag
    logic signed [8:0] as_t;
    always_comb begin
        as_t = 9'sd0;
        if (as_op)
            as_t = $signed({as_in1[7], as_in1}) - $signed({as_in2[7], as_in2});
        else
            as_t = $signed({as_in1[7], as_in1}) + $signed({as_in2[7], as_in2});
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            as_result <= 8'd0;
            as_of     <= 1'b0;
        end else begin
            as_result <= as_t[7:0];
            as_of     <= as_t[8] ^ as_t[7];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && as_of) of_seen = 1'b1;
        if (busy && done) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start at a negedge; optionally pulse start mid-operation.
    task automatic run_mul(input string tag, input logic [7:0] mv,
                           input logic [7:0] qv, input logic [15:0] exp,
                           input bit glitch);
        int n;
        @(negedge clk);
        multiplicand = mv;
        multiplier   = qv;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (glitch && (n == 4 || n == 8)) begin
                multiplicand = 8'h11;
                multiplier   = 8'h22;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, n, 16);
        check({tag, "_prod"}, product, exp);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int gap;
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        of_seen      = 1'b0;
        both_seen    = 1'b0;

        #2 reset = 1'b1;
        #1;
        check("rst_prod", product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in1", as_in1, 0);
        check("rst_in2", as_in2, 0);
        check("rst_op", as_op, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_mul("m7x3", 8'd7, 8'd3, 16'h0015, 0);
        run_mul("mn5x6", 8'hFB, 8'd6, 16'hFFE2, 0);
        run_mul("m6xn5", 8'd6, 8'hFB, 16'hFFE2, 0);
        of_seen = 1'b0;
        run_mul("mn128sq", 8'h80, 8'h80, 16'h4000, 0);
        check("of_seen", of_seen, 1);
        run_mul("m127xn128", 8'h7F, 8'h80, 16'hC080, 0);
        run_mul("zero", 8'd0, 8'h55, 16'h0000, 0);
        run_mul("one_neg1", 8'd1, 8'hFF, 16'hFFFF, 0);
        run_mul("glitch", 8'd12, 8'hF6, 16'hFF88, 1);

        // back-to-back with start held high
        @(negedge clk);
        multiplicand = 8'd5;
        multiplier   = 8'd9;
        start        = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_prod1", product, 16'h002D);
        multiplicand = 8'hF9;
        multiplier   = 8'd8;
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        check("b2b_gap", gap, 18);
        check("b2b_prod2", product, 16'hFFC8);
        @(negedge clk);
        @(negedge clk);

        // reset mid-operation
        @(negedge clk);
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_prod", product, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("mid_rst_quiet", n, 0);
        run_mul("mn3sq", 8'hFD, 8'hFD, 16'h0009, 0);

        check("busy_done_excl", both_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_seq.md
# booth_seq

Sequential radix-2 Booth controller for 8×8 signed multiplication. It sits directly upstream of the `addSub` stage in the multiplier datapath. Each cycle it drives that stage's `input1`, `input2` and `op`, then consumes its `result`/`ofFlag` one clock later. It accumulates the partial product and emits a 16-bit two's-complement product with a start/busy/done handshake.

## Interface
Parameters:
- none (width fixed at 8 to match `addSub`)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; shared with `addSub`
- `start`  in  1  begin a multiply; sampled only in IDLE
- `multiplicand`  in  8  signed M, captured on accepted start
- `multiplier`  in  8  signed Q, captured on accepted start
- `as_in1`  out  8  to `addSub.input1`; always equals register A
- `as_in2`  out  8  to `addSub.input2`; always equals register M
- `as_op`  out  1  to `addSub.op`; 0 = add, 1 = subtract
- `as_result`  in  8  from `addSub.result`
- `as_of`  in  1  from `addSub.ofFlag`
- `product`  out  16  signed result; holds until the next completion
- `busy`  out  1  high in LOAD-accepted ISSUE/CAPTURE states
- `done`  out  1  one-cycle pulse when `product` is updated

## Operation
- Registers:
  - A[7:0]: accumulator
  - Q[7:0]
  - q_1: Booth extra bit
  - M[7:0]
  - cnt[3:0]
  - state
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE, with start=1: load A=0, Q=multiplier, q_1=0, M=multiplicand, cnt=8, then go to ISSUE. With start=0, stay in IDLE.
- ISSUE: `as_in1`/`as_in2`/`as_op` are stable. `addSub` registers its operands at this edge. Go to CAPTURE.
- `as_op` is combinational from {Q[0], q_1}: value 1 when the pair is 2'b10, otherwise 0.
- CAPTURE, by pair {Q[0], q_1}:
  - 01 or 10: the new-A source is `as_result` and the sign bit s = `as_result[7]` ^ `as_of`.
  - 00 or 11: the new-A source is the current A and s = A[7].
- CAPTURE shift: arithmetic right shift of {s, source, Q} → {A, Q, q_1}. That is, A = {s, source[7:1]}, Q = {source[0], Q[7:1]}, q_1 = old Q[0].
- CAPTURE exit: decrement cnt. If cnt becomes 0, write `product` = {A, Q} (post-shift) and go to DONE; else go to ISSUE.
- The sign correction via `as_of` is mandatory; it makes M = −128 correct.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in ISSUE, CAPTURE and DONE. It is not queued.
- Reset, asynchronous at any time including mid-operation:
  - state=IDLE
  - A, Q, q_1, M, cnt, `product` = 0
  - `busy`=0, `done`=0
  - `as_in1`=`as_in2`=0, `as_op`=0
  - A partial product is discarded; `product` does not show it.

## Timing
- An accepted start at edge k gives `busy`=1 after edge k.
- The 8 iterations take 2 cycles each, covering edges k+1 … k+16.
- After edge k+16: `product` is valid, `done`=1, `busy`=0.
- After edge k+17: back in IDLE. The earliest next accepted start is edge k+18, with start held high.
- Total latency from start edge to `done` is 16 cycles; throughput is one multiply per 18 cycles.
- `busy` and `done` are never high together.
- `product` changes only on the final CAPTURE edge or on reset.
- `as_result` is consumed only in CAPTURE, exactly one edge after the ISSUE whose operands produced it. The one-cycle register latency inside `addSub` is part of this contract.

## Test plan
- Reset: assert `reset` with no clock edge → all outputs 0 immediately. Release it, then start with M=7, Q=3 → `done` pulses 16 cycles after the start edge, `product`=0x0015.
- Mixed sign: M=−5 (0xFB), Q=6 → 0xFFE2 (−30). Also swap the operands → same result.
- Overflow path: M=−128, Q=−128 → 0x4000 (16384). M=127, Q=−128 → 0xC080 (−16256). `as_of`=1 must be observed during CAPTURE.
- Zeros and identities: M=0, Q=0x55 → 0x0000. M=1, Q=−1 → 0xFFFF. The 00/11 pairs must leave A unchanged apart from the shift.
- Handshake:
  - Pulse `start` at cycles 5 and 9 of an operation → the second pulse is ignored and `product` reflects the first operands only.
  - Hold `start` high continuously → back-to-back multiplies every 18 cycles.
- Reset mid-operation: assert `reset` in cycle 8 of a multiply → immediate IDLE, `product`=0, `busy`=0, no `done` pulse. A following start with M=−3, Q=−3 → 0x0009.
